// File: rtl/spi_mem_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_mem_bridge_if
//  Description : Bus bundle between the SPI byte link, the on-chip memories
//                and spi_mem_bridge.
//                  rx_data/rx_valid/frame_end : bytes from the deserialiser
//                  tx_data/tx_valid/tx_ready  : bytes to the serialiser
//                  mem_addr/mem_wdata         : shared memory address / word
//                  mem_we/mem_re              : one-hot per-target strobes
//                  mem_rdata                  : per-target read words
//                Modport slave is the bridge side; master is the
//                host/memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_mem_bridge_if #(
    parameter int N_TARGETS  = 3,
    parameter int ADDR_W     = 13,
    parameter int MAX_WBYTES = 16
);
    logic [7:0]                          rx_data;
    logic                                rx_valid;
    logic                                frame_end;
    logic [7:0]                          tx_data;
    logic                                tx_valid;
    logic                                tx_ready;
    logic [ADDR_W-1:0]                   mem_addr;
    logic [8*MAX_WBYTES-1:0]             mem_wdata;
    logic [N_TARGETS-1:0]                mem_we;
    logic [N_TARGETS-1:0]                mem_re;
    logic [N_TARGETS*8*MAX_WBYTES-1:0]   mem_rdata;

    modport slave (
        input  rx_data, rx_valid, frame_end, tx_ready, mem_rdata,
        output tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output rx_data, rx_valid, frame_end, tx_ready, mem_rdata,
        input  tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface
`default_nettype wire

// File: rtl/spi_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_mem_bridge
//  Description : Decodes byte-framed host commands into write/read bursts on
//                N_TARGETS memories (independent word widths) plus a control
//                register at CTRL_ID.
//  Ports       : clk, reset_n (async, active-low)
//                bus         : spi_mem_bridge_if.slave (rx/tx/memory bus)
//                proc_enable : processor enable
//                proc_reset  : 16-cycle processor reset pulse
//                sel_ext     : memories owned by host when 1
//                err         : sticky protocol error
//                busy        : frame in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_mem_bridge #(
    parameter int                      N_TARGETS  = 3,
    parameter int                      ADDR_BYTES = 2,
    parameter int                      ADDR_W     = 13,
    parameter int                      MAX_WBYTES = 16,
    parameter logic [5*N_TARGETS-1:0]  TGT_WBYTES = {5'd1, 5'd16, 5'd10},
    parameter int                      RD_LATENCY = 1,
    parameter int                      CTRL_ID    = 7
) (
    input  wire              clk,
    input  wire              reset_n,
    spi_mem_bridge_if.slave  bus,
    output logic             proc_enable,
    output logic             proc_reset,
    output logic             sel_ext,
    output logic             err,
    output logic             busy
);
    localparam int c_DW = 8 * MAX_WBYTES;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_WDATA   = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_WAIT = 3'd4,
        S_RD_SEND = 3'd5,
        S_DRAIN   = 3'd6
    } state_t;

    state_t             r_state_q, w_state_d;
    logic               r_rw_q, w_rw_d;
    logic [2:0]         r_id_q, w_id_d;
    logic [3:0]         r_acnt_q, w_acnt_d;         // address bytes received
    logic [4:0]         r_bcnt_q, w_bcnt_d;         // write: bytes in word; read: bytes left
    logic [c_DW-1:0]    r_word_q, w_word_d;         // write pack / read shift buffer
    logic [1:0]         r_wait_q, w_wait_d;
    logic [ADDR_W-1:0]  r_addr_q, w_addr_d;
    logic [c_DW-1:0]    r_wdata_q, w_wdata_d;
    logic [N_TARGETS-1:0] r_we_q, w_we_d, r_re_q, w_re_d;
    logic [7:0]         r_tx_data_q, w_tx_data_d;
    logic               r_tx_valid_q, w_tx_valid_d;
    logic               r_en_q, w_en_d, r_sel_q, w_sel_d, r_err_q, w_err_d;
    logic               r_prst_q, w_prst_d, r_busy_q, w_busy_d;
    logic [4:0]         r_prst_cnt_q, w_prst_cnt_d;

    logic               w_is_ctrl;
    logic [4:0]         w_wbytes;
    logic [N_TARGETS-1:0] w_onehot;
    logic [c_DW-1:0]    w_rd_word, w_rd_aligned, w_st_aligned;
    logic [7:0]         w_status;

    function automatic logic [4:0] f_wbytes(input logic [2:0] id);
        f_wbytes = 5'd1;
        for (int i = 0; i < N_TARGETS; i++)
            if (int'(id) == i) f_wbytes = TGT_WBYTES[5*i +: 5];
    endfunction

    function automatic logic [c_DW-1:0] f_mask(input logic [4:0] nb);
        f_mask = '0;
        for (int i = 0; i < MAX_WBYTES; i++)
            if (i < int'(nb)) f_mask[8*i +: 8] = 8'hFF;
    endfunction

    always_comb begin
        w_onehot  = '0;
        w_rd_word = '0;
        for (int i = 0; i < N_TARGETS; i++) begin
            w_onehot[i] = (r_id_q == 3'(i));
            if (r_id_q == 3'(i)) w_rd_word = bus.mem_rdata[c_DW*i +: c_DW];
        end
    end

    assign w_is_ctrl    = (r_id_q == 3'(CTRL_ID));
    assign w_wbytes     = f_wbytes(r_id_q);
    assign w_status     = {4'b0, r_err_q, r_prst_q, r_sel_q, r_en_q};
    // Read words are left-justified so the first byte to send is always on top.
    assign w_rd_aligned = (w_rd_word & f_mask(w_wbytes)) << (8 * (MAX_WBYTES - int'(w_wbytes)));
    assign w_st_aligned = c_DW'(w_status) << (c_DW - 8);

    always_comb begin
        w_state_d    = r_state_q;
        w_rw_d       = r_rw_q;
        w_id_d       = r_id_q;
        w_acnt_d     = r_acnt_q;
        w_bcnt_d     = r_bcnt_q;
        w_word_d     = r_word_q;
        w_wait_d     = r_wait_q;
        w_addr_d     = r_addr_q;
        w_wdata_d    = r_wdata_q;
        w_we_d       = '0;
        w_re_d       = '0;
        w_tx_data_d  = r_tx_data_q;
        w_tx_valid_d = r_tx_valid_q;
        w_en_d       = r_en_q;
        w_sel_d      = r_sel_q;
        w_err_d      = r_err_q;
        w_prst_d     = r_prst_q;
        w_prst_cnt_d = r_prst_cnt_q;
        w_busy_d     = r_busy_q;

        if (r_prst_q) begin
            if (r_prst_cnt_q == 5'd1) begin
                w_prst_d     = 1'b0;
                w_prst_cnt_d = 5'd0;
            end else begin
                w_prst_cnt_d = r_prst_cnt_q - 5'd1;
            end
        end

        // Address advances on the cycle after the write strobe.
        if (|r_we_q) w_addr_d = r_addr_q + ADDR_W'(1);

        case (r_state_q)
            S_IDLE: if (bus.rx_valid) begin
                w_rw_d   = bus.rx_data[7];
                w_id_d   = bus.rx_data[6:4];
                w_busy_d = 1'b1;
                w_acnt_d = 4'd0;
                w_bcnt_d = 5'd0;
                if (int'(bus.rx_data[6:4]) >= N_TARGETS && int'(bus.rx_data[6:4]) != CTRL_ID) begin
                    w_err_d   = 1'b1;
                    w_state_d = S_DRAIN;
                end else begin
                    w_state_d = S_ADDR;
                end
            end
            S_ADDR: if (bus.rx_valid) begin
                if (!w_is_ctrl) w_addr_d = ADDR_W'({r_addr_q, bus.rx_data});
                w_acnt_d = r_acnt_q + 4'd1;
                if (r_acnt_q == 4'(ADDR_BYTES - 1))
                    w_state_d = r_rw_q ? S_RD_REQ : S_WDATA;
            end
            S_WDATA: if (bus.rx_valid) begin
                if (w_is_ctrl) begin
                    w_en_d  = bus.rx_data[0];
                    w_sel_d = bus.rx_data[1];
                    if (bus.rx_data[2]) w_err_d = 1'b0;
                    if (bus.rx_data[3]) begin
                        w_prst_d     = 1'b1;
                        w_prst_cnt_d = 5'd16;
                    end
                end else begin
                    w_word_d = c_DW'({r_word_q, bus.rx_data});
                    if (r_bcnt_q + 5'd1 == w_wbytes) begin
                        w_bcnt_d = 5'd0;
                        if (r_sel_q) begin
                            w_wdata_d = w_word_d & f_mask(w_wbytes);
                            w_we_d    = w_onehot;
                        end else begin
                            w_err_d = 1'b1;
                        end
                    end else begin
                        w_bcnt_d = r_bcnt_q + 5'd1;
                    end
                end
            end
            S_RD_REQ: begin
                if (w_is_ctrl) begin
                    w_word_d     = w_st_aligned;
                    w_tx_data_d  = w_status;
                    w_tx_valid_d = 1'b1;
                    w_bcnt_d     = 5'd1;
                    w_state_d    = S_RD_SEND;
                end else begin
                    w_re_d    = w_onehot;
                    w_wait_d  = 2'd0;
                    w_state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (r_wait_q == 2'(RD_LATENCY)) begin
                    w_word_d     = w_rd_aligned;
                    w_tx_data_d  = w_rd_aligned[c_DW-1 -: 8];
                    w_tx_valid_d = 1'b1;
                    w_bcnt_d     = w_wbytes;
                    w_state_d    = S_RD_SEND;
                end else begin
                    w_wait_d = r_wait_q + 2'd1;
                end
            end
            S_RD_SEND: if (r_tx_valid_q && bus.tx_ready) begin
                if (r_bcnt_q == 5'd1) begin
                    w_tx_valid_d = 1'b0;
                    if (!w_is_ctrl) w_addr_d = r_addr_q + ADDR_W'(1);
                    w_state_d = S_RD_REQ;
                end else begin
                    w_word_d    = r_word_q << 8;
                    w_tx_data_d = w_word_d[c_DW-1 -: 8];
                    w_bcnt_d    = r_bcnt_q - 5'd1;
                end
            end
            S_DRAIN: ;
            default: w_state_d = S_IDLE;
        endcase

        // Frame end is applied after the byte of the same cycle was processed.
        if (bus.frame_end) begin
            if (w_state_d == S_ADDR) w_err_d = 1'b1;
            if (w_state_d == S_WDATA && w_bcnt_d != 5'd0) w_err_d = 1'b1;
            w_state_d    = S_IDLE;
            w_busy_d     = 1'b0;
            w_tx_valid_d = 1'b0;
            w_re_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q    <= S_IDLE;
            r_rw_q       <= 1'b0;
            r_id_q       <= 3'd0;
            r_acnt_q     <= 4'd0;
            r_bcnt_q     <= 5'd0;
            r_word_q     <= '0;
            r_wait_q     <= 2'd0;
            r_addr_q     <= '0;
            r_wdata_q    <= '0;
            r_we_q       <= '0;
            r_re_q       <= '0;
            r_tx_data_q  <= 8'd0;
            r_tx_valid_q <= 1'b0;
            r_en_q       <= 1'b0;
            r_sel_q      <= 1'b1;
            r_err_q      <= 1'b0;
            r_prst_q     <= 1'b0;
            r_prst_cnt_q <= 5'd0;
            r_busy_q     <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_rw_q       <= w_rw_d;
            r_id_q       <= w_id_d;
            r_acnt_q     <= w_acnt_d;
            r_bcnt_q     <= w_bcnt_d;
            r_word_q     <= w_word_d;
            r_wait_q     <= w_wait_d;
            r_addr_q     <= w_addr_d;
            r_wdata_q    <= w_wdata_d;
            r_we_q       <= w_we_d;
            r_re_q       <= w_re_d;
            r_tx_data_q  <= w_tx_data_d;
            r_tx_valid_q <= w_tx_valid_d;
            r_en_q       <= w_en_d;
            r_sel_q      <= w_sel_d;
            r_err_q      <= w_err_d;
            r_prst_q     <= w_prst_d;
            r_prst_cnt_q <= w_prst_cnt_d;
            r_busy_q     <= w_busy_d;
        end
    end

    assign bus.tx_data   = r_tx_data_q;
    assign bus.tx_valid  = r_tx_valid_q;
    assign bus.mem_addr  = r_addr_q;
    assign bus.mem_wdata = r_wdata_q;
    assign bus.mem_we    = r_we_q;
    assign bus.mem_re    = r_re_q;
    assign proc_enable   = r_en_q;
    assign proc_reset    = r_prst_q;
    assign sel_ext       = r_sel_q;
    assign err           = r_err_q;
    assign busy          = r_busy_q;
endmodule
`default_nettype wire

// File: tb/tb_spi_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_mem_bridge
//  Description : Scoreboard bench for spi_mem_bridge. Stimulus pushes expected
//                memory writes, read strobes and tx bytes into queues; a
//                monitor pops and compares whenever the DUT presents one.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_mem_bridge;
    localparam int c_N   = 3;
    localparam int c_AB  = 2;
    localparam int c_AW  = 13;
    localparam int c_MW  = 16;
    localparam int c_RDL = 2;
    localparam int c_CTL = 7;
    localparam int c_DW  = 8 * c_MW;
    localparam logic [127:0] c_PAT = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    typedef struct packed {
        logic [2:0]   sel;
        logic [12:0]  addr;
        logic [127:0] data;
    } acc_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic proc_enable, proc_reset, sel_ext, err, busy;
    int   total = 0;
    int   bad = 0;

    acc_t       exp_wr[$];
    acc_t       exp_re[$];
    logic [7:0] exp_tx[$];
    acc_t       m_acc;
    logic [7:0] m_byte;
    logic [c_DW-1:0] r_pipe0, r_pipe1;

    spi_mem_bridge_if #(.N_TARGETS(c_N), .ADDR_W(c_AW), .MAX_WBYTES(c_MW)) bus ();

    spi_mem_bridge #(
        .N_TARGETS(c_N), .ADDR_BYTES(c_AB), .ADDR_W(c_AW), .MAX_WBYTES(c_MW),
        .TGT_WBYTES({5'd1, 5'd16, 5'd10}), .RD_LATENCY(c_RDL), .CTRL_ID(c_CTL)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .proc_enable(proc_enable), .proc_reset(proc_reset),
        .sel_ext(sel_ext), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Target 1 memory: two-cycle read pipeline; only address 0x123 holds c_PAT.
    always @(posedge clk) begin
        r_pipe0 <= bus.mem_re[1] ? ((bus.mem_addr == 13'h0123) ? c_PAT : ~c_PAT) : '0;
        r_pipe1 <= r_pipe0;
    end
    assign bus.mem_rdata = {{c_DW{1'b0}}, r_pipe1, {c_DW{1'b0}}};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every DUT write strobe, read strobe and tx handshake is matched.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.mem_we != '0) begin
                if (exp_wr.size() == 0) chk("unexpected_we", 128'(bus.mem_we), 128'(0));
                else begin
                    m_acc = exp_wr.pop_front();
                    chk("we_sel",  128'(bus.mem_we),   128'(m_acc.sel));
                    chk("we_addr", 128'(bus.mem_addr), 128'(m_acc.addr));
                    chk("we_data", 128'(bus.mem_wdata), m_acc.data);
                end
            end
            if (bus.mem_re != '0) begin
                if (exp_re.size() == 0) chk("unexpected_re", 128'(bus.mem_re), 128'(0));
                else begin
                    m_acc = exp_re.pop_front();
                    chk("re_sel",  128'(bus.mem_re),   128'(m_acc.sel));
                    chk("re_addr", 128'(bus.mem_addr), 128'(m_acc.addr));
                end
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_tx.size() == 0) chk("unexpected_tx", 128'(bus.tx_data), 128'hFFFF);
                else begin
                    m_byte = exp_tx.pop_front();
                    chk("tx_byte", 128'(bus.tx_data), 128'(m_byte));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic end_frame();
        bus.frame_end = 1'b1;
        tick();
        bus.frame_end = 1'b0;
        repeat (2) tick();
    endtask

    task automatic push_acc(input bit is_wr, input logic [2:0] s, input logic [12:0] a,
                            input logic [127:0] d);
        acc_t e;
        e.sel  = s;
        e.addr = a;
        e.data = d;
        if (is_wr) exp_wr.push_back(e);
        else       exp_re.push_back(e);
    endtask

    task automatic handshakes(input int n);
        int waited;
        for (int i = 0; i < n; i++) begin
            waited = 0;
            while (!bus.tx_valid && waited < 20) begin
                tick();
                waited++;
            end
            if (!bus.tx_valid) begin
                chk("tx_timeout", 128'(bus.tx_valid), 128'(1));
                return;
            end
            bus.tx_ready = 1'b1;
            tick();
            bus.tx_ready = 1'b0;
            tick();
        end
    endtask

    task automatic wait_re_empty();
        int n;
        n = 0;
        while (exp_re.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        chk("re_timeout", 128'(exp_re.size()), 128'(0));
    endtask

    task automatic check_reset_vals();
        chk("rst_tx_data",  128'(bus.tx_data),   128'(0));
        chk("rst_tx_valid", 128'(bus.tx_valid),  128'(0));
        chk("rst_mem_addr", 128'(bus.mem_addr),  128'(0));
        chk("rst_wdata",    128'(bus.mem_wdata), 128'(0));
        chk("rst_we",       128'(bus.mem_we),    128'(0));
        chk("rst_re",       128'(bus.mem_re),    128'(0));
        chk("rst_enable",   128'(proc_enable),   128'(0));
        chk("rst_preset",   128'(proc_reset),    128'(0));
        chk("rst_sel_ext",  128'(sel_ext),       128'(1));
        chk("rst_err",      128'(err),           128'(0));
        chk("rst_busy",     128'(busy),          128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] pat;
        int cnt;
        pat = c_PAT;
        bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.frame_end = 1'b0; bus.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        reset_n = 1'b1;
        tick();

        // Write target 2 (1-byte words) at 5, 6.
        push_acc(1, 3'b100, 13'd5, 128'hAA);
        push_acc(1, 3'b100, 13'd6, 128'hBB);
        send_byte(8'h20); chk("busy_in_frame", 128'(busy), 128'(1));
        send_byte(8'h00); send_byte(8'h05); send_byte(8'hAA); send_byte(8'hBB);
        end_frame();
        chk("busy_after_frame", 128'(busy), 128'(0));
        chk("err_t2_write", 128'(err), 128'(0));

        // Write target 0 (10-byte words), then a 3-byte partial word.
        push_acc(1, 3'b001, 13'd3, 128'h0102030405060708090A);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
        for (int b = 1; b <= 13; b++) send_byte(8'(b));
        end_frame();
        chk("err_partial", 128'(err), 128'(1));

        // Control write (header 0x70: write, id 7): enable, sel_ext, reset pulse.
        send_byte(8'h70); send_byte(8'h00); send_byte(8'h00);
        bus.rx_data = 8'h0B; bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        cnt = 0;
        while (proc_reset && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("preset_len", 128'(cnt), 128'(16));
        chk("ctl_enable", 128'(proc_enable), 128'(1));
        chk("ctl_sel_ext", 128'(sel_ext), 128'(1));
        chk("ctl_err_kept", 128'(err), 128'(1));
        send_byte(8'h04);
        chk("ctl_err_clear", 128'(err), 128'(0));
        chk("ctl_sel_off", 128'(sel_ext), 128'(0));
        chk("ctl_en_off", 128'(proc_enable), 128'(0));
        end_frame();

        // sel_ext=0: memory word dropped, error raised.
        send_byte(8'h20); send_byte(8'h00); send_byte(8'h09); send_byte(8'h55);
        end_frame();
        chk("err_sel_off", 128'(err), 128'(1));

        send_byte(8'h70); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
        chk("ctl2_err", 128'(err), 128'(0));
        chk("ctl2_sel", 128'(sel_ext), 128'(1));
        chk("ctl2_en", 128'(proc_enable), 128'(1));
        end_frame();

        // Control read: status {0,err=0,prst=0,sel=1,en=1} repeated.
        repeat (3) exp_tx.push_back(8'h03);
        send_byte(8'hF0); send_byte(8'h00); send_byte(8'h00);
        handshakes(3);
        end_frame();
        chk("ctl_rd_txv", 128'(bus.tx_valid), 128'(0));

        // Read target 1 (16-byte words) at 0x123, then burst to 0x124.
        push_acc(0, 3'b010, 13'h0123, 128'h0);
        push_acc(0, 3'b010, 13'h0124, 128'h0);
        for (int i = 0; i < 16; i++) exp_tx.push_back(pat[127-8*i -: 8]);
        send_byte(8'h90); send_byte(8'h01); send_byte(8'h23);
        handshakes(16);
        wait_re_empty();
        end_frame();
        chk("rd_busy", 128'(busy), 128'(0));
        chk("rd_txv", 128'(bus.tx_valid), 128'(0));

        // Address wrap; upper address bits dropped.
        push_acc(1, 3'b100, 13'h1FFF, 128'h11);
        push_acc(1, 3'b100, 13'h0000, 128'h22);
        send_byte(8'h20); send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'h11); send_byte(8'h22);
        end_frame();
        chk("wrap_err", 128'(err), 128'(0));

        // Invalid target id 3.
        send_byte(8'h30);
        chk("bad_id_err", 128'(err), 128'(1));
        chk("bad_id_busy", 128'(busy), 128'(1));
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        end_frame();
        chk("bad_id_done", 128'(busy), 128'(0));
        send_byte(8'h70); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
        end_frame();
        chk("err_cleared", 128'(err), 128'(0));

        // Reset in the middle of a 10-byte word.
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
        for (int b = 0; b < 5; b++) send_byte(8'hC0 + 8'(b));
        chk("pre_rst_addr", 128'(bus.mem_addr), 128'(7));
        reset_n = 1'b0;
        #1;
        check_reset_vals();
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Next frame decodes normally.
        push_acc(1, 3'b100, 13'h0010, 128'h5A);
        send_byte(8'h20); send_byte(8'h00); send_byte(8'h10); send_byte(8'h5A);
        end_frame();
        chk("post_rst_err", 128'(err), 128'(0));

        repeat (5) tick();
        chk("wr_left", 128'(exp_wr.size()), 128'(0));
        chk("re_left", 128'(exp_re.size()), 128'(0));
        chk("tx_left", 128'(exp_tx.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
